// File: rtl/disconnect_scan_sched.sv
// Four-channel disconnect monitor: synchronised sample strobes share one
// round-robin peak tracker; a window FSM applies confirm hysteresis and reports peaks.
module disconnect_scan_sched #(
  parameter logic [31:0] WINDOW_CYCLES = 32'd3_000_000_000,
  parameter logic [15:0] THRESHOLD     = 16'h1000,
  parameter int unsigned CONFIRM       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ch_data,
  input  logic [3:0]  ch_data_en,
  input  logic        enable,
  output logic [3:0]  disconnect,
  output logic        win_done,
  output logic        peak_valid,
  output logic [1:0]  peak_ch,
  output logic [15:0] peak_out
);

  localparam int          DATA_W      = 16;
  localparam int          NCH         = 4;
  localparam logic [1:0]  CONFIRM_SAT = 2'(CONFIRM);
  localparam logic [31:0] LAST_CNT    = WINDOW_CYCLES - 32'd1;

  typedef enum logic [2:0] {IDLE, RUN, CLOSE, REP0, REP1, REP2, REP3} state_t;

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c >= CONFIRM_SAT) ? c : c + 2'd1;
  endfunction

  state_t            state, state_nx;
  logic [31:0]       timer;
  logic              tc;
  logic [NCH-1:0]    en_p0, en_p1, en_p2, rise_p2, pending, gnt_mask, above;
  logic [1:0]        ptr, cand, gnt_ch;
  logic              gnt_vld;
  logic [DATA_W-1:0] hold_p2 [NCH];
  logic [DATA_W-1:0] peak    [NCH];
  logic [DATA_W-1:0] snap    [NCH];
  logic [1:0]        cnt     [NCH];
  logic [1:0]        cnt_inc [NCH];

  // p0/p1: synchroniser, p2: edge register and sample capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_p0 <= '0;
      en_p1 <= '0;
      en_p2 <= '0;
    end else begin
      en_p0 <= ch_data_en;
      en_p1 <= en_p0;
      en_p2 <= en_p1;
    end
  end

  assign rise_p2 = en_p1 & ~en_p2;

  always_ff @(posedge clk) begin
    for (int n = 0; n < NCH; n++)
      if (rise_p2[n]) hold_p2[n] <= ch_data[DATA_W*n +: DATA_W];
  end

  // Arbiter: scan downward so the candidate closest to ptr wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = ptr;
    cand    = ptr;
    if (state == RUN) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        cand = ptr + 2'(i);
        if (pending[cand]) begin
          gnt_vld = 1'b1;
          gnt_ch  = cand;
        end
      end
    end
  end

  assign gnt_mask = gnt_vld ? (4'b0001 << gnt_ch) : 4'b0000;

  // p3: pending set, grant, peak tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ptr     <= '0;
      for (int n = 0; n < NCH; n++) peak[n] <= '0;
    end else if (!enable) begin
      pending <= '0;
      for (int n = 0; n < NCH; n++) peak[n] <= '0;
    end else begin
      pending <= (pending & ~gnt_mask) | rise_p2;
      if (gnt_vld) begin
        ptr          <= gnt_ch + 2'd1;
        peak[gnt_ch] <= max_u(peak[gnt_ch], hold_p2[gnt_ch]);
      end
      if (state == CLOSE)
        for (int n = 0; n < NCH; n++) peak[n] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLOSE)
      for (int n = 0; n < NCH; n++) snap[n] <= peak[n];
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      above[n]   = peak[n] > THRESHOLD;
      cnt_inc[n] = sat_inc(cnt[n]);
    end
  end

  // Hysteresis: a channel flips only after CONFIRM consecutive disagreeing windows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disconnect <= 4'b1111;
      for (int n = 0; n < NCH; n++) cnt[n] <= '0;
    end else if (!enable) begin
      for (int n = 0; n < NCH; n++) cnt[n] <= '0;
    end else if (state == CLOSE) begin
      for (int n = 0; n < NCH; n++) begin
        if (above[n] == ~disconnect[n]) begin
          cnt[n] <= '0;
        end else if (cnt_inc[n] == CONFIRM_SAT) begin
          disconnect[n] <= ~disconnect[n];
          cnt[n]        <= '0;
        end else begin
          cnt[n] <= cnt_inc[n];
        end
      end
    end
  end

  assign tc = (state == RUN) && (timer == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= (enable && state == RUN) ? timer + 32'd1 : 32'd0;
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     if (tc) state_nx = CLOSE;
        CLOSE:   state_nx = REP0;
        REP0:    state_nx = REP1;
        REP1:    state_nx = REP2;
        REP2:    state_nx = REP3;
        REP3:    state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    win_done   = (state == REP0);
    peak_valid = 1'b0;
    peak_ch    = 2'd0;
    peak_out   = '0;
    case (state)
      REP0: begin peak_valid = enable; peak_ch = 2'd0; peak_out = snap[0]; end
      REP1: begin peak_valid = enable; peak_ch = 2'd1; peak_out = snap[1]; end
      REP2: begin peak_valid = enable; peak_ch = 2'd2; peak_out = snap[2]; end
      REP3: begin peak_valid = enable; peak_ch = 2'd3; peak_out = snap[3]; end
      default: ;
    endcase
  end

endmodule

// File: doc/disconnect_scan_sched.md
# disconnect_scan_sched

Shared-datapath scheduler for 4-channel sensor-disconnect monitoring in the signal-detect path. It accepts per-channel sample strobes and arbitrates them round-robin into a single peak-tracking comparator. A single window timer sequences the per-channel decision windows. At each window close it applies a confirm-count hysteresis to every channel and reports per-channel peaks serially to the status/telemetry logic.

## Interface
- `WINDOW_CYCLES`, default 32'd3_000_000_000 (60 s at 50 MHz): RUN length in clk cycles. Legal range 8 to 2^32-1.
- `THRESHOLD`, default 16'h1000: connect threshold. A channel counts as connected for a window only if its peak is strictly greater than this value.
- `CONFIRM`, default 2: consecutive disagreeing windows needed to flip a channel's status. Legal range 1 to 3.

Ports:
- `clk`  input  1  system clock, 50 MHz.
- `rst`  input  1  asynchronous, active-low reset.
- `ch_data`  input  64  packed samples; channel n occupies [16n+15:16n], unsigned.
- `ch_data_en`  input  4  per-channel sample strobe (level; rising edge marks a new sample).
- `enable`  input  1  run/stop.
- `disconnect`  output  4  per-channel status; 1 = disconnected.
- `win_done`  output  1  one-cycle pulse when `disconnect` has just been updated.
- `peak_valid`  output  1  high for the 4 report cycles.
- `peak_ch`  output  2  channel being reported.
- `peak_out`  output  16  that channel's window peak.

## Operation
- Reset values: `disconnect`=4'b1111; `win_done`, `peak_valid`=0; `peak_ch`, `peak_out`=0. Also cleared: timer, peaks, pending bits, confirm counters. RR pointer resets to ch0. FSM resets to IDLE.
- Per-channel input path: 2-flop synchronizer, then an edge register. On a detected rise, `ch_data` is captured into that channel's hold register and the channel's pending bit is set.
  - A new rise on an already-pending channel overwrites the hold register; the pending bit stays set and the older sample is dropped.
- Arbiter: one grant per cycle, only in RUN. Round-robin among pending channels, starting from the pointer. After a grant to channel n, the pointer moves to (n+1) mod 4.
  - The granted channel's pending bit clears, unless a new rise on that channel arrives in the same cycle, in which case it stays set with the new data.
  - Peak update: peak[n] <= max(peak[n], hold[n]).
- FSM:
  - IDLE: enter RUN when `enable`=1, with timer=0.
  - RUN: timer counts 0..WINDOW_CYCLES-1. At the terminal count, go to CLOSE.
  - CLOSE (1 cycle): snapshot all peaks and clear the live peaks to 0. For each channel, compute above = snap > THRESHOLD and let agree = (above == ~disconnect[n]).
    - If agree, clear that channel's confirm counter.
    - If not, increment it. On reaching CONFIRM, toggle `disconnect[n]` and clear the counter.
    - Then go to REP0.
  - REP0..REP3 (1 cycle each): `peak_valid`=1, `peak_ch`=k, `peak_out`=snap[k]. After REP3, return to RUN with timer=0.
- During CLOSE/REPORT, grants are paused. Edges are still captured and stay pending, then are served in the next window.
- `enable`=0 in any state: next state is IDLE.
  - Timer, live peaks, pending bits and confirm counters are cleared.
  - `peak_valid`=0.
  - `disconnect` holds its last value.
  - An interrupted window produces no evaluation.

## Timing
- Edge-to-pending latency: 3 cycles after `ch_data_en` rises. The source holds `ch_data` stable for at least 4 cycles after the rise.
- Grant occurs at the earliest 1 cycle after pending is set. The peak is updated at the grant edge.
- A grant in the RUN terminal-count cycle is included in the closing window.
- Four simultaneous pendings are served in 4 consecutive cycles.
- `disconnect` changes at the CLOSE→REP0 edge. `win_done`=1 during REP0 only.
- Window period: WINDOW_CYCLES + 5 cycles.
- No arithmetic overflow: the max-compare is 16-bit; the confirm counter is 2-bit and saturates at CONFIRM.

## Test plan
- Reset check: assert `rst`=0 mid-REPORT → immediately `disconnect`=4'hF, `peak_valid`=0, `win_done`=0. After release with `enable`=1, the first `win_done` arrives at cycle WINDOW_CYCLES+1 from RUN entry.
- Connect hysteresis: WINDOW_CYCLES=100, CONFIRM=2. Ch0 sample 16'h1200 in each of 2 windows → `disconnect[0]` stays 1 after window 1 and becomes 0 at the window-2 `win_done`.
- Threshold boundary: ch1 samples 16'h1000 every window → `disconnect[1]` stays 1 and peak reports 16'h1000. Changing to 16'h1001 flips the status after 2 windows.
- Arbitration: all four strobes rise in the same cycle with values 10/20/30/40 and the pointer at ch2 → grant order ch2, ch3, ch0, ch1 on consecutive cycles. REP0..3 report 0x000A, 0x0014, 0x001E, 0x0028.
- Edge during REPORT: ch3 rise with value 16'h2000 in REP1 → not in this report; served in the next RUN window and reported as 16'h2000 in the following REP3.
- Enable drop: `enable`=0 at timer=50 → IDLE, no `win_done`, `disconnect` held. Re-enable → next `win_done` arrives 101 cycles later, with peaks from the new window only.
